// File: rtl/group_add_pkg.sv
// Shared sizing helpers and the output narrowing function for group_add_acc.
// Define GROUP_ADD_SAT_EN to make fit() saturate instead of wrap.
package group_add_pkg;

  // Widest intermediate sum fit() can take; sums are sign-extended up to this width.
  localparam int MAX_W = 64;

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int sum_width(input int num_w, input int group_nb, input int acc_nb);
    return num_w + tree_levels(group_nb) + ((acc_nb <= 1) ? 0 : $clog2(acc_nb));
  endfunction

  function automatic int lanes_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = (r + 1) / 2;
    return r;
  endfunction

  // Result is sign-extended to MAX_W; the caller keeps the low num_w bits.
  function automatic logic signed [MAX_W-1:0] fit(input logic signed [MAX_W-1:0] v,
                                                  input int num_w);
`ifdef GROUP_ADD_SAT_EN
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    one = 1;
    hi  = (one <<< (num_w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (MAX_W - num_w)) >>> (MAX_W - num_w);
`endif
  endfunction

endpackage

// File: rtl/group_add_level.sv
// One registered adder-tree level: pairs lanes and adds them, an odd lane passes through.
module group_add_level
  import group_add_pkg::*;
#(
  parameter int IN_NB = 4,
  parameter int IN_W  = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic [IN_NB*IN_W-1:0]                    in_data,
  input  logic                                     in_valid,
  output logic [lanes_at(IN_NB, 1)*(IN_W+1)-1:0]   out_data,
  output logic                                     out_valid
);

  localparam int OUT_NB = lanes_at(IN_NB, 1);

  logic [OUT_NB*(IN_W+1)-1:0] sum_next;

  for (genvar j = 0; j < OUT_NB; j++) begin : g_lane
    logic signed [IN_W-1:0] a;
    assign a = in_data[2*j*IN_W +: IN_W];
    if (2*j + 1 < IN_NB) begin : g_pair
      logic signed [IN_W-1:0] b;
      assign b = in_data[(2*j+1)*IN_W +: IN_W];
      assign sum_next[j*(IN_W+1) +: IN_W+1] = (IN_W+1)'(a) + (IN_W+1)'(b);
    end else begin : g_pass
      assign sum_next[j*(IN_W+1) +: IN_W+1] = (IN_W+1)'(a);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_data  <= sum_next;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/group_add_acc.sv
// Pipelined adder tree over GROUP_NB lanes with optional accumulation of ACC_NB beats.
// Define GROUP_ADD_SAT_EN for a saturating output; otherwise the result wraps.
module group_add_acc
  import group_add_pkg::*;
#(
  parameter int GROUP_NB  = 4,
  parameter int NUM_WIDTH = 16,
  parameter int ACC_NB    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [NUM_WIDTH-1:0]          dn_data,
  output logic                          dn_valid,
  input  logic                          dn_ready
);

  localparam int LVL    = tree_levels(GROUP_NB);
  localparam int TREE_W = NUM_WIDTH + LVL;
  localparam int SUM_W  = sum_width(NUM_WIDTH, GROUP_NB, ACC_NB);
  localparam int CNT_W  = (ACC_NB > 1) ? $clog2(ACC_NB) : 1;

  logic                     en;
  logic signed [TREE_W-1:0] tree_sum;
  logic                     tree_valid;
  logic signed [SUM_W-1:0]  acc_next;
  logic                     group_done;

  // A single stall signal freezes every stage while the output is held.
  assign en       = !dn_valid || dn_ready;
  assign up_ready = en;

  if (LVL == 0) begin : g_no_tree
    assign tree_sum   = up_data;
    assign tree_valid = up_valid;
  end else begin : g_tree
    for (genvar k = 0; k < LVL; k++) begin : g_stage
      localparam int IN_NB  = lanes_at(GROUP_NB, k);
      localparam int IN_W   = NUM_WIDTH + k;
      localparam int OUT_NB = lanes_at(GROUP_NB, k + 1);

      logic [IN_NB*IN_W-1:0]      lvl_in;
      logic                       lvl_in_valid;
      logic [OUT_NB*(IN_W+1)-1:0] lvl_out;
      logic                       lvl_out_valid;

      if (k == 0) begin : g_head
        assign lvl_in       = up_data;
        assign lvl_in_valid = up_valid;
      end else begin : g_link
        assign lvl_in       = g_stage[k-1].lvl_out;
        assign lvl_in_valid = g_stage[k-1].lvl_out_valid;
      end

      group_add_level #(
        .IN_NB (IN_NB),
        .IN_W  (IN_W)
      ) u_level (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (lvl_in),
        .in_valid  (lvl_in_valid),
        .out_data  (lvl_out),
        .out_valid (lvl_out_valid)
      );
    end
    assign tree_sum   = g_stage[LVL-1].lvl_out;
    assign tree_valid = g_stage[LVL-1].lvl_out_valid;
  end

  if (ACC_NB > 1) begin : g_acc
    logic signed [SUM_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    // cnt==0 marks the first beat of a group, so a stale acc is never folded in.
    assign acc_next   = ((cnt == '0) ? '0 : acc) + SUM_W'(tree_sum);
    assign group_done = tree_valid && (cnt == CNT_W'(ACC_NB - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
        cnt <= '0;
      end else if (en && tree_valid) begin
        if (cnt == CNT_W'(ACC_NB - 1)) begin
          cnt <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end else begin : g_no_acc
    assign acc_next   = SUM_W'(tree_sum);
    assign group_done = tree_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (en) begin
      dn_valid <= group_done;
      if (group_done) dn_data <= NUM_WIDTH'(fit(MAX_W'(acc_next), NUM_WIDTH));
    end
  end

endmodule
